song_grid_renderer: RTL and testbench

// - Screen-side partner of the song sequencer FSM. Holds the visible note grid
//   (ROWS x 4 lanes), shifts in a new row on shiftSong, then redraws the grid

---
 rtl/song_grid_renderer_if.sv | 26 ++
 rtl/song_grid_renderer.sv | 134 +++++++++++++
 tb/tb_song_grid_renderer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/song_grid_renderer_if.sv
// Sequencer <-> grid renderer bundle: control pulses in, VGA pixel stream and status out.
// master = sequencer/screen side, slave = renderer.
interface song_grid_renderer_if;
    logic       startKey;
    logic       songDone;
    logic       shiftSong;
    logic       beatIncremented;
    logic [3:0] noteRow;
    logic       readyForSong;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [3:0] hitRow;
    logic       protocolErr;

    modport master (
        output startKey, songDone, shiftSong, beatIncremented, noteRow,
        input  readyForSong, x, y, colour, plot, hitRow, protocolErr
    );

    modport slave (
        input  startKey, songDone, shiftSong, beatIncremented, noteRow,
        output readyForSong, x, y, colour, plot, hitRow, protocolErr
    );
endinterface

// File: rtl/song_grid_renderer.sv
// Note-grid renderer: shifts note rows in, redraws the ROWS x 4 grid to VGA one pixel per cycle.
// Latency: beat at T -> pixels T+1..T+N -> readyForSong at T+N+1. No backpressure; beats while busy set protocolErr.
// Optional HIT_LINE_EN appends a white hit line below the grid.
module song_grid_renderer #(
    parameter int ROWS   = 8,
    parameter int CELL_W = 8,
    parameter int CELL_H = 8,
    parameter int X0     = 40,
    parameter int Y0     = 20
) (
    input logic                 clock,
    input logic                 reset,
    song_grid_renderer_if.slave bus
);
    localparam int XC_W = $clog2(4 * CELL_W);
    localparam int YC_W = $clog2(ROWS * CELL_H + 1);
    localparam int CH_L = $clog2(CELL_H);
    localparam int R_W  = $clog2(ROWS);

    localparam logic [XC_W-1:0] XC_LAST = XC_W'(4 * CELL_W - 1);
`ifdef HIT_LINE_EN
    localparam logic [YC_W-1:0] YC_LAST = YC_W'(ROWS * CELL_H);
`else
    localparam logic [YC_W-1:0] YC_LAST = YC_W'(ROWS * CELL_H - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ROWS-1:0][3:0]   row_q, row_d;
    logic [XC_W-1:0]        xc_q, xc_d;
    logic [YC_W-1:0]        yc_q, yc_d;
    logic                   key_q;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   start_rise;
    logic [1:0]             lane;
    logic [R_W-1:0]         r_idx;
    logic [2:0]             lane_c;
    logic [2:0]             pix_c;
    logic                   drawing;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            key_q   <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            key_q   <= bus.startKey;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign start_rise = bus.startKey & ~key_q & bus.songDone & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        err_d   = err_q;
        start_d = start_rise;

        // The shifted grid lands on the same edge that starts a draw, so a coincident draw sees it.
        if (start_rise) begin
            row_d = '0;
        end else if (bus.shiftSong) begin
            row_d = {row_q[ROWS-2:0], bus.noteRow};
        end

        if (bus.beatIncremented && state_q != S_IDLE) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.beatIncremented) begin
                    state_d = S_DRAW;
                    xc_d    = '0;
                    yc_d    = '0;
                end
            end
            S_DRAW: begin
                if (xc_q == XC_LAST) begin
                    xc_d = '0;
                    if (yc_q == YC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        yc_d = yc_q + 1'b1;
                    end
                end else begin
                    xc_d = xc_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane  = xc_q[XC_W-1 -: 2];
        r_idx = R_W'(yc_q >> CH_L);
        case (lane)
            2'd0:    lane_c = 3'b100;
            2'd1:    lane_c = 3'b010;
            2'd2:    lane_c = 3'b001;
            default: lane_c = 3'b110;
        endcase
        pix_c = row_q[r_idx][lane] ? lane_c : 3'b000;
`ifdef HIT_LINE_EN
        if (yc_q == YC_LAST) begin
            pix_c = 3'b111;
        end
`endif
    end

    assign drawing          = (state_q == S_DRAW);
    assign bus.plot         = drawing;
    assign bus.x            = drawing ? 8'(X0 + int'(xc_q)) : 8'd0;
    assign bus.y            = drawing ? 7'(Y0 + int'(yc_q)) : 7'd0;
    assign bus.colour       = drawing ? pix_c : 3'b000;
    assign bus.readyForSong = start_q | (state_q == S_DONE);
    assign bus.hitRow       = row_q[ROWS-1];
    assign bus.protocolErr  = err_q;
endmodule

// File: tb/tb_song_grid_renderer.sv
// Directed bench for song_grid_renderer at default parameters; inputs change and outputs are sampled on negedge.
module tb_song_grid_renderer;
    localparam int N_GRID = 2048;
`ifdef HIT_LINE_EN
    localparam int N_PIX = N_GRID + 32;
`else
    localparam int N_PIX = N_GRID;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] m_row [8];

    always #5 clk = ~clk;

    song_grid_renderer_if sif ();

    song_grid_renderer dut (
        .clock (clk),
        .reset (rst),
        .bus   (sif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_shift(input logic [3:0] v);
        for (int i = 7; i >= 1; i--) m_row[i] = m_row[i-1];
        m_row[0] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_row[i] = 4'b0000;
    endtask

    task automatic shift_in(input logic [3:0] v);
        sif.shiftSong = 1'b1;
        sif.noteRow   = v;
        @(negedge clk);
        sif.shiftSong = 1'b0;
        model_shift(v);
    endtask

    function automatic logic [2:0] exp_colour(input int p);
        int xc, yc, lane, r;
        logic [2:0] lc;
        xc = p % 32;
        yc = p / 32;
        if (yc >= 64) return 3'b111;
        lane = xc / 8;
        r    = yc / 8;
        case (lane)
            0:       lc = 3'b100;
            1:       lc = 3'b010;
            2:       lc = 3'b001;
            default: lc = 3'b110;
        endcase
        return m_row[r][lane] ? lc : 3'b000;
    endfunction

    // Beat at cycle 0; sample j corresponds to cycle T+j.
    task automatic draw(input string tag, input logic with_shift, input logic [3:0] v,
                        input int beat2_at, input int rst_at);
        int plots, bad, rdy_cnt, rdy_at, stop, p;
        plots = 0; bad = 0; rdy_cnt = 0; rdy_at = -1;
        if (with_shift) begin
            sif.shiftSong = 1'b1;
            sif.noteRow   = v;
            model_shift(v);
        end
        sif.beatIncremented = 1'b1;
        @(negedge clk);
        sif.beatIncremented = 1'b0;
        sif.shiftSong       = 1'b0;
        stop = (rst_at > 0) ? rst_at : N_PIX;
        for (int j = 1; j <= N_PIX + 20; j++) begin
            if (sif.plot === 1'b1) plots++;
            if (sif.readyForSong === 1'b1) begin
                rdy_cnt++;
                if (rdy_at < 0) rdy_at = j;
            end
            p = j - 1;
            if (j <= stop) begin
                if (sif.plot !== 1'b1 || sif.x !== 8'(40 + p % 32) ||
                    sif.y !== 7'(20 + p / 32) || sif.colour !== exp_colour(p))
                    bad++;
            end else if (sif.plot !== 1'b0) begin
                bad++;
            end
            if (rst_at > 0 && j == rst_at + 1) check({tag, " plot after reset"}, 32'(sif.plot), 32'd0);
            sif.beatIncremented = (j == beat2_at);
            rst = (rst_at > 0 && j == rst_at);
            @(negedge clk);
        end
        sif.beatIncremented = 1'b0;
        rst = 1'b0;
        if (rst_at > 0) model_clear();
        check({tag, " bad pixels"}, 32'(bad), 32'd0);
        check({tag, " plot count"}, 32'(plots), 32'(stop));
        if (rst_at > 0) begin
            check({tag, " ready count"}, 32'(rdy_cnt), 32'd0);
        end else begin
            check({tag, " ready count"}, 32'(rdy_cnt), 32'd1);
            check({tag, " ready cycle"}, 32'(rdy_at), 32'(N_PIX + 1));
        end
    endtask

    initial begin
        int cnt, first;
        sif.startKey = 1'b0;
        sif.songDone = 1'b0;
        sif.shiftSong = 1'b0;
        sif.beatIncremented = 1'b0;
        sif.noteRow = 4'b0000;
        model_clear();

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("reset plot", 32'(sif.plot), 32'd0);
        check("reset ready", 32'(sif.readyForSong), 32'd0);
        check("reset hitRow", 32'(sif.hitRow), 32'd0);
        check("reset err", 32'(sif.protocolErr), 32'd0);
        check("reset x", 32'(sif.x), 32'd0);
        check("reset y", 32'(sif.y), 32'd0);
        check("reset colour", 32'(sif.colour), 32'd0);

        repeat (8) shift_in(4'b1111);
        check("fill hitRow", 32'(sif.hitRow), 32'hF);

        sif.songDone = 1'b1;
        sif.startKey = 1'b1;
        cnt = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sif.readyForSong === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        model_clear();
        check("start pulse count", 32'(cnt), 32'd1);
        check("start pulse cycle", 32'(first), 32'd0);
        check("start clears grid", 32'(sif.hitRow), 32'd0);
        sif.startKey = 1'b0;
        sif.songDone = 1'b0;
        repeat (3) @(negedge clk);

        sif.startKey = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sif.readyForSong === 1'b1) cnt++;
        end
        check("start ignored notdone", 32'(cnt), 32'd0);
        sif.startKey = 1'b0;
        repeat (3) @(negedge clk);

        draw("draw1", 1'b1, 4'b0001, 0, 0);
        check("draw1 err", 32'(sif.protocolErr), 32'd0);

        shift_in(4'h1); shift_in(4'h2); shift_in(4'h4); shift_in(4'h8);
        shift_in(4'h3); shift_in(4'h5); shift_in(4'h6); shift_in(4'h9);
        check("hitRow after 8", 32'(sif.hitRow), 32'h1);
        shift_in(4'h0);
        check("hitRow after 9", 32'(sif.hitRow), 32'h2);
        repeat (2) @(negedge clk);

        draw("draw2", 1'b0, 4'h0, 100, 0);
        check("draw2 err", 32'(sif.protocolErr), 32'd1);
        repeat (2) @(negedge clk);

        draw("draw3", 1'b0, 4'h0, 0, 500);
        check("draw3 err cleared", 32'(sif.protocolErr), 32'd0);
        check("draw3 hitRow cleared", 32'(sif.hitRow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
